fft_input_reorder_buffer: RTL
=============================

# fft_input_reorder_buffer

Collects N complex samples from the byte-pair sample assembler (Re/Im plus one-cycle valid strobe) into an internal buffer. Each sample is written at its bit-reversed index. Once the frame is complete, the buffer streams it out in memory order under a valid/ready handshake, so the FFT core receives bit-reversed input order with frame start and end markers. The block sits between the sample assembler and the FFT butterfly pipeline.

## Interface
- BIT_WIDTH, 32, width of each Re/Im word (two's complement)
- N, 16, frame length in complex samples (power of two)
- SIZE, 4, log2(N); address width
- REVERSE, 1, 1 = bit-reversed write address; 0 = natural order (bypass for DIF use)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle strobe; in_re/in_im valid
- in_re  in  BIT_WIDTH  real part
- in_im  in  BIT_WIDTH  imaginary part
- out_ready  in  1  FFT core accepts current output word
- out_valid  out  1  out_* holds a valid word
- out_re  out  BIT_WIDTH  real part of output word
- out_im  out  BIT_WIDTH  imaginary part of output word
- out_addr  out  SIZE  memory index of the current output word (0..N-1)
- out_first  out  1  high with word 0 of the frame
- out_last  out  1  high with word N-1 of the frame
- busy  out  1  high in DRAIN
- overflow  out  1  one-cycle pulse when an input sample is dropped

## Operation
- Storage: N x (2·BIT_WIDTH) register array. No reset is applied to the contents.
- States:
  - FILL, entered on reset. A write counter wr_cnt starts at 0.
  - DRAIN.
- FILL:
  - On in_valid: mem[rev(wr_cnt)] <= {in_re, in_im}; wr_cnt++.
  - rev() reverses the SIZE bits of wr_cnt. It is the identity when REVERSE=0.
  - The write with wr_cnt = N-1 wraps wr_cnt to 0 and transitions to DRAIN.
- DRAIN entry: rd_ptr <= 0. The output registers load mem[0]; out_valid=1; out_first=1.
- DRAIN handshake:
  - When out_valid && out_ready and rd_ptr < N-1: rd_ptr++ and the output registers load mem[rd_ptr+1].
  - out_last=1 when the loaded index is N-1. out_first=1 only for index 0.
  - When out_valid && out_ready and rd_ptr == N-1: out_valid, out_first and out_last clear; state returns to FILL.
- When out_valid=1 and out_ready=0, every out_* signal holds stable.
- in_valid during DRAIN: the sample is discarded, overflow pulses for 1 cycle, and the memory and wr_cnt are unchanged.
- No arithmetic is performed on the data. Words pass through bit-exact.

## Timing
- Reset values: out_valid=0, out_re=0, out_im=0, out_addr=0, out_first=0, out_last=0, busy=0, overflow=0. State is FILL with wr_cnt=0 and rd_ptr=0.
- Latency: the Nth in_valid is sampled at edge k. State is DRAIN after edge k, and out_valid=1 with word 0 is visible after edge k+1.
- Throughput: with out_ready held high, N words are delivered on N consecutive cycles. The last accepted word returns the block to FILL on the same edge, so the next frame's first in_valid can be accepted on the following edge.
- busy rises with the DRAIN state and falls on the edge that accepts the last word.
- Reset asserted mid-FILL or mid-DRAIN:
  - All outputs return to their reset values immediately (asynchronously).
  - The partial frame is abandoned. The next frame starts at wr_cnt=0.
- overflow is combinationally independent of out_ready. It is registered, appearing one cycle after the dropped in_valid.

## Structure
- Shared package fft_pkg holds:
  - the state localparams (FILL, DRAIN);
  - a bit_reverse function parameterised by SIZE, reused by the FFT twiddle/address logic.
- One sub-module: addr_bit_reverse (combinational, SIZE-bit in/out, REVERSE bypass). It computes the write address.
- The FSM, counters and output registers live in the top module.

## Test plan
- **Bit-reversed frame:** N=16, REVERSE=1, 16 strobes with in_re=i<<8, in_im=-(i<<8), out_ready=1.
  - Output in_re order: 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 (<<8), with in_im the matching negated values.
  - out_first on word 0 only; out_last on word 15 only.
  - out_valid rises 1 cycle after the 16th strobe.
- **Natural order:** REVERSE=0, same stimulus -> output order 0..15.
- **Backpressure:** out_ready toggled 1,0,0,1,... -> each word is held stable while out_ready=0. No word is lost or duplicated, and exactly 16 words are accepted.
- **Overflow:** 3 in_valid strobes during DRAIN -> 3 overflow pulses. The output frame is unchanged, and the next frame fills from index 0.
- **Reset mid-FILL:** 7 samples, pulse rst_n low, then 16 new samples -> only the new frame is output, in correct order. All outputs are 0 while reset is low.
- **Back-to-back frames:** in_valid every cycle for 2 frames, with out_ready=1 and the second frame's strobes starting after busy falls -> both frames are delivered intact with zero overflow.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: reorder-buffer state encoding and the bit-reversal
// helper that the butterfly address and twiddle logic also use.
package fft_pkg;

    // Reorder buffer phases: collect a frame, then stream it out.
    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Widest address the bit-reversal helper handles.
    localparam int MAX_ADDR_W = 16;

    // Reverses the low 'size' bits of 'value'. Bits at and above 'size' come back as 0.
    function automatic logic [MAX_ADDR_W-1:0] bit_reverse(
        input logic [MAX_ADDR_W-1:0] value,
        input int                    size
    );
        logic [MAX_ADDR_W-1:0] result;
        result = '0;
        for (int i = 0; i < MAX_ADDR_W; i++) begin
            if (i < size) begin
                result[i] = value[size-1-i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_input_reorder_buffer_if.sv
// Sample-in / word-out bundle of the FFT input reorder buffer.
// master = sample source and FFT core side, slave = the reorder buffer.
interface fft_input_reorder_buffer_if #(
    parameter int BIT_WIDTH = 32,
    parameter int SIZE      = 4
);
    logic                 in_valid;
    logic [BIT_WIDTH-1:0] in_re;
    logic [BIT_WIDTH-1:0] in_im;
    logic                 out_ready;
    logic                 out_valid;
    logic [BIT_WIDTH-1:0] out_re;
    logic [BIT_WIDTH-1:0] out_im;
    logic [SIZE-1:0]      out_addr;
    logic                 out_first;
    logic                 out_last;
    logic                 busy;
    logic                 overflow;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  out_valid, out_re, out_im, out_addr, out_first, out_last, busy, overflow
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output out_valid, out_re, out_im, out_addr, out_first, out_last, busy, overflow
    );
endinterface

// File: rtl/addr_bit_reverse.sv
// Write-address generator: bit-reversed sample index, or the index itself
// when the reorder is bypassed (DIF use).
module addr_bit_reverse
    import fft_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int REVERSE = 1
) (
    input  logic [SIZE-1:0] addr_i,
    output logic [SIZE-1:0] addr_o
);

    logic [SIZE-1:0] rev_addr;

    assign rev_addr = SIZE'(bit_reverse(MAX_ADDR_W'(addr_i), SIZE));
    assign addr_o   = (REVERSE != 0) ? rev_addr : addr_i;

endmodule

// File: rtl/fft_input_reorder_buffer.sv
// FFT input reorder buffer: stores N complex samples at their bit-reversed
// index, then streams the frame out in memory order with first/last markers.
module fft_input_reorder_buffer
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N         = 16,
    parameter int SIZE      = 4,
    parameter int REVERSE   = 1
) (
    input logic                       clk,
    input logic                       rst_n,
    fft_input_reorder_buffer_if.slave bus
);

    localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);

    state_t                 state_q, state_d;
    logic [SIZE-1:0]        wr_cnt_q, wr_cnt_d;
    logic [SIZE-1:0]        rd_ptr_q, rd_ptr_d;
    logic [BIT_WIDTH-1:0]   out_re_q, out_re_d;
    logic [BIT_WIDTH-1:0]   out_im_q, out_im_d;
    logic [SIZE-1:0]        out_addr_q, out_addr_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_first_q, out_first_d;
    logic                   out_last_q, out_last_d;
    logic                   overflow_q, overflow_d;

    logic [2*BIT_WIDTH-1:0] mem_q [N];
    logic [SIZE-1:0]        wr_addr;
    logic                   wr_en;
    logic                   accept;
    logic                   load_first;
    logic                   load_next;
    logic [SIZE-1:0]        rd_idx;
    logic [2*BIT_WIDTH-1:0] rd_word;

    addr_bit_reverse #(
        .SIZE    (SIZE),
        .REVERSE (REVERSE)
    ) u_addr_bit_reverse (
        .addr_i (wr_cnt_q),
        .addr_o (wr_addr)
    );

    // Samples are only stored while collecting; anything arriving during drain is dropped.
    assign wr_en      = (state_q == ST_FILL) && bus.in_valid;
    assign accept     = out_valid_q && bus.out_ready;
    // First cycle of drain has nothing presented yet: fetch word 0.
    assign load_first = (state_q == ST_DRAIN) && !out_valid_q;
    assign load_next  = accept && (rd_ptr_q != LAST_IDX);
    assign rd_idx     = load_first ? '0 : rd_ptr_q + 1'b1;
    assign rd_word    = mem_q[rd_idx];

    // Sample storage, written at the (possibly reversed) write address; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {bus.in_re, bus.in_im};
        end
    end

    // Next-state logic for the fill/drain sequencer and the output word registers.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        overflow_d  = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (bus.in_valid) begin
                    // Counter wraps naturally to 0 on the last sample of the frame.
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                overflow_d = bus.in_valid;
                if (load_first || load_next) begin
                    rd_ptr_d    = rd_idx;
                    out_re_d    = rd_word[2*BIT_WIDTH-1:BIT_WIDTH];
                    out_im_d    = rd_word[BIT_WIDTH-1:0];
                    out_addr_d  = rd_idx;
                    out_valid_d = 1'b1;
                    out_first_d = (rd_idx == '0);
                    out_last_d  = (rd_idx == LAST_IDX);
                end else if (accept) begin
                    // Final word taken: frame done, ready for the next one on the next edge.
                    out_valid_d = 1'b0;
                    out_first_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_FILL;
                end
            end
        endcase
    end

    // Control and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q == ST_DRAIN);
    assign bus.overflow  = overflow_q;

endmodule
